// File: rtl/logic_unit_seq_pkg.sv
// rtl/logic_unit_seq_pkg.sv - shared vector layout, FSM encoding and golden model for the logic-unit self-test
package logic_unit_seq_pkg;

   localparam int VB_AND = 4;
   localparam int VB_OR  = 3;
   localparam int VB_XOR = 2;
   localparam int VB_A   = 1;
   localparam int VB_B   = 0;

   localparam int NVEC = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Active modes are OR-combined; no mode selected yields 0.
   function automatic logic lu_golden(input logic [4:0] vec);
      return (vec[VB_AND] & vec[VB_A] & vec[VB_B])
           | (vec[VB_OR]  & (vec[VB_A] | vec[VB_B]))
           | (vec[VB_XOR] & (vec[VB_A] ^ vec[VB_B]));
   endfunction

endpackage

// File: rtl/logic_unit_golden.sv
// rtl/logic_unit_golden.sv - combinational reference for the 3-mode logic unit
module logic_unit_golden
   import logic_unit_seq_pkg::*;
(
   input  logic [4:0] vec,
   output logic       g
);

   assign g = lu_golden(vec);

endmodule

// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - walks all 32 vectors into the logic unit and records a per-vector fail map
module logic_unit_seq
   import logic_unit_seq_pkg::*;
#(
   parameter int SETTLE_CYC = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  dut_vec,
   input  logic        dut_e,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [5:0]  fail_cnt,
   output logic        first_fail_vld,
   output logic [4:0]  first_fail_idx,
   output logic [31:0] led
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

   generate
      if (SETTLE_CYC < 1) begin : g_bad_settle
         $error("SETTLE_CYC must be at least 1");
      end
   endgenerate

   state_t        state;
   logic [4:0]    idx;
   logic [CW-1:0] cnt;
   logic          g;
   logic          mismatch;

   logic_unit_golden u_golden (
      .vec (idx),
      .g   (g)
   );

   assign mismatch = (dut_e != g);

   // led holds the inverted fail map directly, so a cleared bit marks a failed vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         idx            <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
         dut_vec        <= '0;
         led            <= '1;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start && !abort) begin
                  state          <= ST_SETTLE;
                  idx            <= '0;
                  cnt            <= '0;
                  led            <= '1;
                  fail_cnt       <= '0;
                  first_fail_vld <= 1'b0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  dut_vec        <= '0;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  dut_vec <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= ST_SAMPLE;
                  end
               end
            end
            ST_SAMPLE: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  dut_vec <= '0;
               end else begin
                  if (mismatch) begin
                     led[idx] <= 1'b0;
                     fail_cnt <= fail_cnt + 6'd1;
                     if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= idx;
                     end
                  end
                  if (idx == 5'(NVEC - 1)) begin
                     state   <= ST_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     dut_vec <= '0;
                     pass    <= (fail_cnt == 6'd0) && !mismatch;
                  end else begin
                     idx     <= idx + 5'd1;
                     dut_vec <= idx + 5'd1;
                     cnt     <= '0;
                     state   <= ST_SETTLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - self-checking bench for logic_unit_seq
module tb_logic_unit_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  dut_vec;
   logic        dut_e;
   logic        busy, done, pass, first_fail_vld;
   logic [5:0]  fail_cnt;
   logic [4:0]  first_fail_idx;
   logic [31:0] led;
   logic        ref_g;
   logic [1:0]  mode = 2'd0;   // 0 correct unit, 1 stuck at 0, 2 stuck at 1

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [5:0]  fcnt;
      logic        fvld;
      logic [4:0]  fidx;
      logic [31:0] led;
      logic        pass;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   logic_unit_seq #(.SETTLE_CYC(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .dut_vec        (dut_vec),
      .dut_e          (dut_e),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_cnt       (fail_cnt),
      .first_fail_vld (first_fail_vld),
      .first_fail_idx (first_fail_idx),
      .led            (led)
   );

   logic_unit_golden u_unit (
      .vec (dut_vec),
      .g   (ref_g)
   );

   assign dut_e = (mode == 2'd0) ? ref_g : (mode == 2'd2);

   function automatic exp_t model(input logic [1:0] m, input int upto);
      exp_t e;
      e.fcnt = '0;
      e.fvld = 1'b0;
      e.fidx = '0;
      e.led  = '1;
      for (int v = 0; v < upto; v++) begin
         logic [4:0] b;
         logic       gv, f;
         b  = 5'(v);
         gv = (b[4] & b[1] & b[0]) | (b[3] & (b[1] | b[0])) | (b[2] & (b[1] ^ b[0]));
         f  = (m == 2'd1) ? gv : (m == 2'd2) ? !gv : 1'b0;
         if (f) begin
            e.led[v] = 1'b0;
            e.fcnt   = e.fcnt + 6'd1;
            if (!e.fvld) begin
               e.fvld = 1'b1;
               e.fidx = 5'(v);
            end
         end
      end
      e.pass = (e.fcnt == 6'd0);
      return e;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_result(input string nm);
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (fail_cnt !== e.fcnt) begin
         n_bad++;
         $display("FAIL %s fail_cnt got %0d want %0d", nm, fail_cnt, e.fcnt);
      end
      n_vec++;
      if (led !== e.led) begin
         n_bad++;
         $display("FAIL %s led got %h want %h", nm, led, e.led);
      end
      n_vec++;
      if (first_fail_vld !== e.fvld || (e.fvld && first_fail_idx !== e.fidx)) begin
         n_bad++;
         $display("FAIL %s first_fail got vld=%0b idx=%0d want vld=%0b idx=%0d",
                  nm, first_fail_vld, first_fail_idx, e.fvld, e.fidx);
      end
   endtask

   // Runs from the start pulse to done; c counts cycles after the edge that sampled start.
   task automatic run_full(input logic [1:0] m, input bit extra_starts, input string nm);
      exp_t e;
      mode = m;
      e = model(m, 32);
      sb.push_back(e);
      pulse_start();
      for (int c = 0; c < 160; c++) begin
         start = extra_starts && (c == 37 || c == 101);
         n_vec++;
         if (dut_vec !== 5'(c / 5) || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s seq c=%0d got vec=%0d busy=%0b done=%0b want vec=%0d busy=1 done=0",
                     nm, c, dut_vec, busy, done, c / 5);
         end
         @(negedge clk);
      end
      start = 1'b0;
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || dut_vec !== 5'd0 || pass !== e.pass) begin
         n_bad++;
         $display("FAIL %s done@160 got done=%0b busy=%0b vec=%0d pass=%0b want 1 0 0 %0b",
                  nm, done, busy, dut_vec, pass, e.pass);
      end
      check_result(nm);
   endtask

   task automatic wait_vec(input logic [4:0] v, input string nm);
      int n;
      n = 0;
      while (dut_vec !== v && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (dut_vec !== v) begin
         n_bad++;
         $display("FAIL %s wait_vec timeout got %0d want %0d", nm, dut_vec, v);
      end
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_cnt !== 6'd0 ||
          first_fail_vld !== 1'b0 || first_fail_idx !== 5'd0 || dut_vec !== 5'd0 ||
          led !== 32'hFFFF_FFFF) begin
         n_bad++;
         $display("FAIL reset got busy=%0b done=%0b pass=%0b cnt=%0d vld=%0b idx=%0d vec=%0d led=%h",
                  busy, done, pass, fail_cnt, first_fail_vld, first_fail_idx, dut_vec, led);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_correct();
      run_full(2'd0, 1'b0, "correct");
      n_vec++;
      if (pass !== 1'b1 || fail_cnt !== 6'd0 || led !== 32'hFFFF_FFFF) begin
         n_bad++;
         $display("FAIL correct_const got pass=%0b cnt=%0d led=%h want 1 0 ffffffff", pass, fail_cnt, led);
      end
   endtask

   task automatic test_stuck0();
      run_full(2'd1, 1'b0, "stuck0");
      n_vec++;
      if (fail_cnt !== 6'd18 || first_fail_idx !== 5'd5 || led[5] !== 1'b0 ||
          led[0] !== 1'b1 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL stuck0_const got cnt=%0d idx=%0d led=%h pass=%0b want 18 5 bit5=0 bit0=1 0",
                  fail_cnt, first_fail_idx, led, pass);
      end
   endtask

   task automatic test_stuck1();
      run_full(2'd2, 1'b0, "stuck1");
      n_vec++;
      if (fail_cnt !== 6'd14 || first_fail_idx !== 5'd0 || led[0] !== 1'b0 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL stuck1_const got cnt=%0d idx=%0d led0=%0b pass=%0b want 14 0 0 0",
                  fail_cnt, first_fail_idx, led[0], pass);
      end
   endtask

   task automatic test_abort();
      mode = 2'd1;
      sb.push_back(model(2'd1, 10));
      pulse_start();
      wait_vec(5'd10, "abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || dut_vec !== 5'd0) begin
         n_bad++;
         $display("FAIL abort got busy=%0b done=%0b vec=%0d want 0 0 0", busy, done, dut_vec);
      end
      check_result("abort_retain");
      run_full(2'd0, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      run_full(2'd0, 1'b1, "start_while_busy");
      run_full(2'd2, 1'b0, "restart_from_done");
   endtask

   task automatic test_rst_midrun();
      mode = 2'd1;
      pulse_start();
      wait_vec(5'd20, "rst_midrun");
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0 || dut_vec !== 5'd0 || led !== 32'hFFFF_FFFF || fail_cnt !== 6'd0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_midrun got busy=%0b vec=%0d led=%h cnt=%0d done=%0b",
                  busy, dut_vec, led, fail_cnt, done);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_correct();
      test_stuck0();
      test_stuck1();
      test_abort();
      test_back_to_back();
      test_rst_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
